// File: rtl/hs_cdc_sync.sv
// Single-word toggle-handshake clock-domain crossing: a source word is parked in
// src_hold and announced by flipping req_tgl; the destination flips ack_tgl back.
module hs_cdc_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_FLOPS = 2,
  parameter bit DST_HOLD   = 1'b0,
  parameter int DROP_CNT_W = 8
) (
  input  logic                  dst_clk,
  input  logic                  src_clk,
  input  logic                  rst_n,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  output logic [DROP_CNT_W-1:0] src_drop_cnt,
  output logic                  dst_valid,
  input  logic                  dst_ready,
  output logic [DATA_WIDTH-1:0] dst_data
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // source domain
  logic [0:0]            src_state;
  logic                  req_tgl;
  logic [DATA_WIDTH-1:0] src_hold;
  logic [SYNC_FLOPS-1:0] ack_sync;
  logic [DROP_CNT_W-1:0] drop_cnt;
  logic                  ack_seen;

  // destination domain
  logic [SYNC_FLOPS-1:0] req_sync;
  logic                  req_last;
  logic                  req_evt;
  logic                  ack_tgl;
  logic                  dst_valid_q;
  logic [DATA_WIDTH-1:0] dst_data_q;

  // The transfer is complete once the returned ack toggle has caught up with req_tgl.
  assign ack_seen = (ack_sync[SYNC_FLOPS-1] == req_tgl);
  assign src_ready    = (src_state == ST_IDLE);
  assign src_drop_cnt = drop_cnt;

  always_ff @(posedge src_clk or negedge rst_n) begin
    if (!rst_n) begin
      src_state <= ST_IDLE;
      req_tgl   <= 1'b0;
      src_hold  <= '0;
      ack_sync  <= '0;
      drop_cnt  <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_FLOPS-2:0], ack_tgl};
      case (src_state)
        ST_IDLE: begin
          if (src_valid) begin
            src_hold  <= src_data;
            req_tgl   <= ~req_tgl;
            src_state <= ST_BUSY;
          end
        end
        default: begin
          if (ack_seen) begin
            src_state <= ST_IDLE;
          end
        end
      endcase
      if (src_valid && !src_ready && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // src_hold is frozen while BUSY, so sampling it here after req_evt is safe.
  assign req_evt = req_sync[SYNC_FLOPS-1] ^ req_last;

  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      req_sync    <= '0;
      req_last    <= 1'b0;
      ack_tgl     <= 1'b0;
      dst_valid_q <= 1'b0;
      dst_data_q  <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_FLOPS-2:0], req_tgl};
      req_last <= req_sync[SYNC_FLOPS-1];
      if (req_evt) begin
        dst_data_q  <= src_hold;
        dst_valid_q <= 1'b1;
        if (!DST_HOLD) begin
          ack_tgl <= ~ack_tgl;
        end
      end else if (!DST_HOLD) begin
        dst_valid_q <= 1'b0;
      end else if (dst_valid_q && dst_ready) begin
        dst_valid_q <= 1'b0;
        ack_tgl     <= ~ack_tgl;
      end
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_hs_cdc_sync.sv
// Directed bench for hs_cdc_sync: pulse and hold modes, drop counter, reset
// mid-transfer, data stability and a long back-to-back run in both clock ratios.
`timescale 1ns/1ps
module tb_hs_cdc_sync;
  localparam int DW      = 32;
  localparam int SF      = 2;
  localparam int N_WORDS = 1000;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rst_n    = 1'b0;
  always #5    clk_fast = ~clk_fast;
  always #13.5 clk_slow = ~clk_slow;

  // d_: pulse mode fast->slow, h_: hold mode, n_: hold mode 4-bit counter, r_: pulse slow->fast
  logic          d_src_valid, d_src_ready, d_dst_valid, d_dst_ready;
  logic [DW-1:0] d_src_data, d_dst_data;
  logic [7:0]    d_drop;
  logic          h_src_valid, h_src_ready, h_dst_valid, h_dst_ready;
  logic [DW-1:0] h_src_data, h_dst_data;
  logic [7:0]    h_drop;
  logic          n_src_valid, n_src_ready, n_dst_valid, n_dst_ready;
  logic [DW-1:0] n_src_data, n_dst_data;
  logic [3:0]    n_drop;
  logic          r_src_valid, r_src_ready, r_dst_valid, r_dst_ready;
  logic [DW-1:0] r_src_data, r_dst_data;
  logic [7:0]    r_drop;

  int n_checks = 0;
  int n_fail   = 0;
  int slow_cnt = 0;
  always @(posedge clk_slow) slow_cnt <= slow_cnt + 1;

  logic [DW-1:0] words_a [N_WORDS];
  logic [DW-1:0] words_b [N_WORDS];
  int rcv_a, rcv_b, mism_a, mism_b, extra_a, extra_b, pa_k, pb_k;
  bit to_a, to_b, pa_rdy, pb_rdy;

  hs_cdc_sync #(.DATA_WIDTH(DW), .SYNC_FLOPS(SF), .DST_HOLD(1'b0), .DROP_CNT_W(8)) u_dut (
    .dst_clk(clk_slow), .src_clk(clk_fast), .rst_n(rst_n),
    .src_valid(d_src_valid), .src_data(d_src_data), .src_ready(d_src_ready),
    .src_drop_cnt(d_drop), .dst_valid(d_dst_valid), .dst_ready(d_dst_ready),
    .dst_data(d_dst_data));

  hs_cdc_sync #(.DATA_WIDTH(DW), .SYNC_FLOPS(SF), .DST_HOLD(1'b1), .DROP_CNT_W(8)) u_hold (
    .dst_clk(clk_slow), .src_clk(clk_fast), .rst_n(rst_n),
    .src_valid(h_src_valid), .src_data(h_src_data), .src_ready(h_src_ready),
    .src_drop_cnt(h_drop), .dst_valid(h_dst_valid), .dst_ready(h_dst_ready),
    .dst_data(h_dst_data));

  hs_cdc_sync #(.DATA_WIDTH(DW), .SYNC_FLOPS(SF), .DST_HOLD(1'b1), .DROP_CNT_W(4)) u_narrow (
    .dst_clk(clk_slow), .src_clk(clk_fast), .rst_n(rst_n),
    .src_valid(n_src_valid), .src_data(n_src_data), .src_ready(n_src_ready),
    .src_drop_cnt(n_drop), .dst_valid(n_dst_valid), .dst_ready(n_dst_ready),
    .dst_data(n_dst_data));

  hs_cdc_sync #(.DATA_WIDTH(DW), .SYNC_FLOPS(SF), .DST_HOLD(1'b0), .DROP_CNT_W(8)) u_rev (
    .dst_clk(clk_fast), .src_clk(clk_slow), .rst_n(rst_n),
    .src_valid(r_src_valid), .src_data(r_src_data), .src_ready(r_src_ready),
    .src_drop_cnt(r_drop), .dst_valid(r_dst_valid), .dst_ready(r_dst_ready),
    .dst_data(r_dst_data));

  task automatic pulse_reset();
    @(posedge clk_fast); #2;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    @(posedge clk_fast); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #20;
    n_checks++; if (d_dst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dst_valid: got %0b want 0", d_dst_valid); end
    n_checks++; if (d_dst_data !== '0) begin n_fail++; $display("FAIL reset_dst_data: got %h want 0", d_dst_data); end
    n_checks++; if (d_drop !== 8'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d want 0", d_drop); end
    #32;
    rst_n = 1'b1;
    @(posedge clk_fast); #1;
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_src_ready: got %0b want 1", d_src_ready); end
    n_checks++; if (h_src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_hold_src_ready: got %0b want 1", h_src_ready); end
    n_checks++; if (r_dst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rev_dst_valid: got %0b want 0", r_dst_valid); end
    $display("[reset] released, outputs at reset values");
  endtask

  task automatic test_single();
    int c0, lat, k;
    @(posedge clk_fast); #1;
    d_src_data  = 32'hDEADBEEF;
    d_src_valid = 1'b1;
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_before: got %0b want 1", d_src_ready); end
    @(posedge clk_fast);
    c0 = slow_cnt;
    #1;
    d_src_valid = 1'b0;
    n_checks++; if (d_src_ready !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0b want 0", d_src_ready); end
    do begin @(posedge clk_slow); #1; end while (!d_dst_valid && (slow_cnt - c0) < 12);
    lat = slow_cnt - c0;
    n_checks++; if (d_dst_valid !== 1'b1 || lat < SF + 1 || lat > SF + 2) begin
      n_fail++; $display("FAIL single_latency: got %0d dst edges (valid=%0b) want %0d..%0d", lat, d_dst_valid, SF + 1, SF + 2);
    end
    n_checks++; if (d_dst_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", d_dst_data); end
    @(posedge clk_slow); #1;
    n_checks++; if (d_dst_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got %0b want 0", d_dst_valid); end
    k = 0;
    do begin @(posedge clk_fast); #1; k++; end while (!d_src_ready && k < 50);
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL single_src_ready_return: got %0b want 1", d_src_ready); end
    n_checks++; if (d_dst_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data_held: got %h want deadbeef", d_dst_data); end
    $display("[single] word deadbeef delivered, latency %0d dst edges", lat);
  endtask

  task automatic test_data_stable();
    logic [DW-1:0] cap;
    bit got;
    int k;
    @(posedge clk_fast); #1;
    d_src_data  = 32'h0F1E2D3C;
    d_src_valid = 1'b1;
    @(posedge clk_fast); #1;
    d_src_valid = 1'b0;
    got = 1'b0;
    cap = '0;
    for (int i = 0; i < 60 && !got; i++) begin
      d_src_data = ~d_src_data ^ DW'(i);
      @(posedge clk_fast); #1;
      if (d_dst_valid) begin got = 1'b1; cap = d_dst_data; end
    end
    n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL stable_valid_seen: got %0b want 1", got); end
    n_checks++; if (cap !== 32'h0F1E2D3C) begin n_fail++; $display("FAIL stable_data: got %h want 0f1e2d3c", cap); end
    k = 0;
    do begin @(posedge clk_fast); #1; k++; end while (!d_src_ready && k < 50);
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL stable_src_ready_return: got %0b want 1", d_src_ready); end
    $display("[stable] captured word 0f1e2d3c survived src_data toggling");
  endtask

  task automatic test_hold();
    int k, held;
    bit rdy_seen;
    @(posedge clk_fast); #1;
    h_dst_ready = 1'b0;
    h_src_data  = 32'h12345678;
    h_src_valid = 1'b1;
    @(posedge clk_fast); #1;
    h_src_valid = 1'b0;
    k = 0;
    do begin @(posedge clk_slow); #1; k++; end while (!h_dst_valid && k < 12);
    n_checks++; if (h_dst_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_rise: got %0b want 1", h_dst_valid); end
    held = 0;
    rdy_seen = 1'b0;
    repeat (20) begin
      if (h_dst_valid === 1'b1 && h_dst_data === 32'h12345678) held++;
      if (h_src_ready !== 1'b0) rdy_seen = 1'b1;
      @(posedge clk_slow); #1;
    end
    n_checks++; if (held != 20) begin n_fail++; $display("FAIL hold_cycles: got %0d want 20", held); end
    n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL hold_src_ready_low: got %0b want 0", rdy_seen); end
    h_dst_ready = 1'b1;
    @(posedge clk_slow); #1;
    h_dst_ready = 1'b0;
    n_checks++; if (h_dst_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_clear: got %0b want 0", h_dst_valid); end
    n_checks++; if (h_dst_data !== 32'h12345678) begin n_fail++; $display("FAIL hold_data_kept: got %h want 12345678", h_dst_data); end
    k = 0;
    do begin @(posedge clk_fast); #1; k++; end while (!h_src_ready && k < 50);
    n_checks++; if (h_src_ready !== 1'b1) begin n_fail++; $display("FAIL hold_src_idle: got %0b want 1", h_src_ready); end
    $display("[hold] word 12345678 held 20 cycles then consumed");
  endtask

  task automatic test_reset_mid();
    int k, spurious;
    @(posedge clk_fast); #1;
    d_src_data  = 32'hCAFEF00D;
    d_src_valid = 1'b1;
    @(posedge clk_fast); #1;
    d_src_valid = 1'b0;
    @(posedge clk_fast); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_src_idle: got %0b want 1", d_src_ready); end
    n_checks++; if (d_dst_data !== '0) begin n_fail++; $display("FAIL midrst_dst_data: got %h want 0", d_dst_data); end
    n_checks++; if (h_dst_data !== '0) begin n_fail++; $display("FAIL midrst_hold_data: got %h want 0", h_dst_data); end
    #3;
    rst_n = 1'b1;
    spurious = 0;
    repeat (20) begin
      @(posedge clk_slow); #1;
      if (d_dst_valid !== 1'b0) spurious++;
    end
    n_checks++; if (spurious != 0) begin n_fail++; $display("FAIL midrst_spurious_valid: got %0d want 0", spurious); end
    n_checks++; if (d_src_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_src_ready: got %0b want 1", d_src_ready); end
    @(posedge clk_fast); #1;
    d_src_data  = 32'hA5A5A5A5;
    d_src_valid = 1'b1;
    @(posedge clk_fast); #1;
    d_src_valid = 1'b0;
    k = 0;
    do begin @(posedge clk_slow); #1; k++; end while (!d_dst_valid && k < 12);
    n_checks++; if (d_dst_valid !== 1'b1 || d_dst_data !== 32'hA5A5A5A5) begin
      n_fail++; $display("FAIL midrst_new_word: got valid=%0b data=%h want valid=1 data=a5a5a5a5", d_dst_valid, d_dst_data);
    end
    k = 0;
    do begin @(posedge clk_fast); #1; k++; end while (!d_src_ready && k < 50);
    $display("[reset_mid] in-flight word discarded, next word a5a5a5a5 delivered");
  endtask

  task automatic test_drop();
    int k;
    pulse_reset();
    h_dst_ready = 1'b0;
    n_dst_ready = 1'b0;
    h_src_data  = 32'h11111111;
    n_src_data  = 32'h22222222;
    h_src_valid = 1'b1;
    n_src_valid = 1'b1;
    @(posedge clk_fast);
    repeat (10) @(posedge clk_fast);
    #1;
    h_src_valid = 1'b0;
    n_checks++; if (h_drop !== 8'd10) begin n_fail++; $display("FAIL drop_count_10: got %0d want 10", h_drop); end
    n_checks++; if (n_drop !== 4'd10) begin n_fail++; $display("FAIL drop_narrow_10: got %0d want 10", n_drop); end
    repeat (5) @(posedge clk_fast);
    #1;
    n_checks++; if (n_drop !== 4'd15) begin n_fail++; $display("FAIL drop_narrow_15: got %0d want 15", n_drop); end
    repeat (5) @(posedge clk_fast);
    #1;
    n_src_valid = 1'b0;
    n_checks++; if (n_drop !== 4'd15) begin n_fail++; $display("FAIL drop_narrow_saturate: got %0d want 15", n_drop); end
    n_checks++; if (h_drop !== 8'd10) begin n_fail++; $display("FAIL drop_count_idle_valid: got %0d want 10", h_drop); end
    h_dst_ready = 1'b1;
    n_dst_ready = 1'b1;
    k = 0;
    do begin @(posedge clk_fast); #1; k++; end while (!(h_src_ready && n_src_ready) && k < 80);
    h_dst_ready = 1'b0;
    n_dst_ready = 1'b0;
    n_checks++; if (h_src_ready !== 1'b1 || n_src_ready !== 1'b1) begin
      n_fail++; $display("FAIL drop_drain: got ready=%0b/%0b want 1/1", h_src_ready, n_src_ready);
    end
    $display("[drop] 10 rejects counted, 4-bit counter saturated at 15 after 20 rejects");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < N_WORDS; i++) begin
      words_a[i] = $urandom;
      words_b[i] = $urandom;
    end
    rcv_a = 0; rcv_b = 0; mism_a = 0; mism_b = 0; extra_a = 0; extra_b = 0;
    to_a = 1'b0; to_b = 1'b0;
    fork
      begin
        @(posedge clk_fast); #1;
        for (int i = 0; i < N_WORDS && !to_a; i++) begin
          d_src_data  = words_a[i];
          d_src_valid = 1'b1;
          pa_k = 0;
          do begin pa_rdy = d_src_ready; @(posedge clk_fast); #1; pa_k++; end while (!pa_rdy && pa_k < 200);
          if (!pa_rdy) to_a = 1'b1;
        end
        d_src_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 12000 && !(rcv_a >= N_WORDS && extra_a >= 30); c++) begin
          @(posedge clk_slow); #1;
          if (d_dst_valid) begin
            if (rcv_a < N_WORDS && d_dst_data !== words_a[rcv_a]) mism_a++;
            rcv_a++;
          end
          if (rcv_a >= N_WORDS) extra_a++;
        end
      end
      begin
        @(posedge clk_slow); #1;
        for (int j = 0; j < N_WORDS && !to_b; j++) begin
          r_src_data  = words_b[j];
          r_src_valid = 1'b1;
          pb_k = 0;
          do begin pb_rdy = r_src_ready; @(posedge clk_slow); #1; pb_k++; end while (!pb_rdy && pb_k < 200);
          if (!pb_rdy) to_b = 1'b1;
        end
        r_src_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 30000 && !(rcv_b >= N_WORDS && extra_b >= 30); c++) begin
          @(posedge clk_fast); #1;
          if (r_dst_valid) begin
            if (rcv_b < N_WORDS && r_dst_data !== words_b[rcv_b]) mism_b++;
            rcv_b++;
          end
          if (rcv_b >= N_WORDS) extra_b++;
        end
      end
    join
    n_checks++; if (to_a !== 1'b0) begin n_fail++; $display("FAIL b2b_fast_slow_accept_timeout: got %0b want 0", to_a); end
    n_checks++; if (rcv_a != N_WORDS) begin n_fail++; $display("FAIL b2b_fast_slow_count: got %0d want %0d", rcv_a, N_WORDS); end
    n_checks++; if (mism_a != 0) begin n_fail++; $display("FAIL b2b_fast_slow_data: got %0d bad words want 0", mism_a); end
    n_checks++; if (to_b !== 1'b0) begin n_fail++; $display("FAIL b2b_slow_fast_accept_timeout: got %0b want 0", to_b); end
    n_checks++; if (rcv_b != N_WORDS) begin n_fail++; $display("FAIL b2b_slow_fast_count: got %0d want %0d", rcv_b, N_WORDS); end
    n_checks++; if (mism_b != 0) begin n_fail++; $display("FAIL b2b_slow_fast_data: got %0d bad words want 0", mism_b); end
    $display("[b2b] fast->slow received %0d words, slow->fast received %0d words", rcv_a, rcv_b);
  endtask

  initial begin
    d_src_valid = 1'b0; d_src_data = '0; d_dst_ready = 1'b0;
    h_src_valid = 1'b0; h_src_data = '0; h_dst_ready = 1'b0;
    n_src_valid = 1'b0; n_src_data = '0; n_dst_ready = 1'b0;
    r_src_valid = 1'b0; r_src_data = '0; r_dst_ready = 1'b0;
    test_reset();
    test_single();
    test_data_stable();
    test_hold();
    test_reset_mid();
    test_drop();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hs_cdc_sync.md
HS_CDC_SYNC -- requirements
Module: hs_cdc_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the transferred word.
REQ-002 SHALL have parameter SYNC_FLOPS, default 2: flops per synchroniser chain; legal range 2..4.
REQ-003 SHALL have parameter DST_HOLD, default 1'b0: 0 makes dst_valid a 1-cycle pulse; 1 holds dst_valid until dst_ready.
REQ-004 SHALL have parameter DROP_CNT_W, default 8: width of the saturating reject counter.
REQ-005 SHALL have port dst_clk, input, 1 bit: destination-domain clock.
REQ-006 SHALL have port src_clk, input, 1 bit: source-domain clock.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low, shared by both domains.
REQ-008 SHALL have port src_valid, input, 1 bit: source offers src_data.
REQ-009 SHALL have port src_data, input, DATA_WIDTH bits: source word.
REQ-010 SHALL have port src_ready, output, 1 bit: the block accepts a word this src_clk cycle.
REQ-011 SHALL have port src_drop_cnt, output, DROP_CNT_W bits: count of rejected offers.
REQ-012 SHALL have port dst_valid, output, 1 bit: dst_data holds a new word.
REQ-013 SHALL have port dst_ready, input, 1 bit: consumer accepts; used only when DST_HOLD=1.
REQ-014 SHALL have port dst_data, output, DATA_WIDTH bits: transferred word.

Function
REQ-015 SHALL run a source FSM on src_clk with states IDLE and BUSY; src_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE with src_valid=1, capture src_data into src_hold, invert req_tgl, and enter BUSY on the same edge.
REQ-017 SHALL keep src_hold constant in BUSY, so the multi-bit word is stable whenever the destination samples it.
REQ-018 SHALL synchronise req_tgl into dst_clk through SYNC_FLOPS flops, then one edge-detect flop; a detected change is req_evt.
REQ-019 SHALL, on req_evt, load dst_data from src_hold and set dst_valid on the next dst_clk edge.
REQ-020 SHALL, when DST_HOLD=0, keep dst_valid high for exactly one dst_clk cycle, ignore dst_ready, and invert ack_tgl on the same edge dst_valid rises.
REQ-021 SHALL, when DST_HOLD=1, hold dst_valid and dst_data until a cycle with dst_valid&dst_ready; on that edge clear dst_valid and invert ack_tgl.
REQ-022 SHALL synchronise ack_tgl into src_clk through SYNC_FLOPS flops; the source returns BUSY->IDLE when the synchronised ack equals req_tgl.
REQ-023 Latency SHALL be SYNC_FLOPS+1 to SYNC_FLOPS+2 dst_clk edges from the src accept edge to dst_valid rising.
REQ-024 SHALL hold dst_data between words; dst_data changes only on REQ-019 loads.
REQ-025 SHALL increment src_drop_cnt on each src_clk cycle with src_valid=1 and src_ready=0, saturating at all-ones (no wrap).
REQ-026 SHALL never lose or duplicate an accepted word: exactly one dst_valid event (pulse or accepted hold) per src accept.
REQ-027 SHALL accept the next word on the first IDLE cycle after return, with no extra bubble beyond REQ-022.

Reset
REQ-028 SHALL, on rst_n=0, immediately force: source FSM to IDLE, src_ready=1 after release, req_tgl=0, ack_tgl=0, all synchroniser flops=0, dst_valid=0, dst_data=0, src_drop_cnt=0.
REQ-029 Reset mid-transfer SHALL discard the in-flight word; after release neither domain sees a spurious req_evt or ack.

Verification
REQ-030 SHALL verify this scenario: src 100 MHz, dst 37 MHz, DST_HOLD=0, accept 0xDEADBEEF -> one dst_valid pulse with dst_data=0xDEADBEEF within SYNC_FLOPS+2 dst cycles; src_ready returns to 1.
REQ-031 SHALL verify this scenario: DST_HOLD=1, dst_ready=0 for 20 dst cycles -> dst_valid held 20 cycles, src_ready stays 0; dst_ready=1 -> valid clears and the source returns to IDLE.
REQ-032 SHALL verify this scenario: src_valid held high for 10 cycles while BUSY -> src_drop_cnt=10; with DROP_CNT_W=4 and 20 rejects -> src_drop_cnt=15.
REQ-033 SHALL verify this scenario: 1000 back-to-back random words, both clock ratios (fast->slow, slow->fast) -> output sequence identical to input, none missing or duplicated.
REQ-034 SHALL verify this scenario: rst_n pulsed low while BUSY -> all outputs reach reset values; after release no dst_valid occurs until a new accept.
REQ-035 SHALL verify this scenario: src_data toggled every cycle while BUSY -> dst_data equals the word captured at accept.
